// File: rtl/cic_interp.sv
// I/Q CIC interpolator. STAGES low-rate combs feed a one-sample hold register.
// A phase counter paced by i_strobe zero-stuffs into STAGES high-rate integrators.
module cic_interp #(
  parameter int WIDTH     = 16,
  parameter int FACTOR    = 313,
  parameter int DELAY     = 2,
  parameter int STAGES    = 5,
  parameter int ACC_WIDTH = 56,
  parameter int OUT_SHIFT = 39
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_inph_data,
  input  logic [WIDTH-1:0] i_quad_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_strobe,
  output logic [WIDTH-1:0] o_inph_data,
  output logic [WIDTH-1:0] o_quad_data,
  output logic             o_valid,
  output logic             o_underrun
);

  localparam int PHASE_W = (FACTOR > 1) ? $clog2(FACTOR) : 1;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  logic               hold_full;
  acc_t               hold_i, hold_q;
  logic [PHASE_W-1:0] phase;
  logic               slot0, take, accept;
  acc_t               in_i, in_q, inj_i, inj_q;

  acc_t               comb_i [STAGES];
  acc_t               comb_q [STAGES];
  acc_t               hist_i [STAGES][DELAY];
  acc_t               hist_q [STAGES][DELAY];
  logic [STAGES-1:0]  comb_vld;
  acc_t               cin_i  [STAGES];
  acc_t               cin_q  [STAGES];
  logic [STAGES-1:0]  cin_vld;

  acc_t               integ_i [STAGES];
  acc_t               integ_q [STAGES];
  logic [STAGES-1:0]  integ_vld;
  acc_t               iin_i   [STAGES];
  acc_t               iin_q   [STAGES];
  logic [STAGES-1:0]  iin_vld;

  assign slot0   = i_strobe && (phase == '0);
  assign take    = slot0 && hold_full;
  assign o_ready = !hold_full || take;
  assign accept  = i_valid && o_ready;

  assign in_i  = {{(ACC_WIDTH-WIDTH){i_inph_data[WIDTH-1]}}, i_inph_data};
  assign in_q  = {{(ACC_WIDTH-WIDTH){i_quad_data[WIDTH-1]}}, i_quad_data};
  assign inj_i = take ? hold_i : '0;
  assign inj_q = take ? hold_q : '0;

  // Stage k consumes stage k-1's registered output; stage 0 consumes the port.
  always_comb begin
    cin_i[0]   = in_i;
    cin_q[0]   = in_q;
    cin_vld[0] = accept;
    iin_i[0]   = inj_i;
    iin_q[0]   = inj_q;
    iin_vld[0] = i_strobe;
    for (int unsigned k = 1; k < STAGES; k++) begin
      cin_i[k]   = comb_i[k-1];
      cin_q[k]   = comb_q[k-1];
      cin_vld[k] = comb_vld[k-1];
      iin_i[k]   = integ_i[k-1];
      iin_q[k]   = integ_q[k-1];
      iin_vld[k] = integ_vld[k-1];
    end
  end

  // The whole comb pipeline freezes while the hold register is full and not
  // being taken, so a finished comb result can never overwrite an unread one.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      comb_vld <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        comb_i[k] <= '0;
        comb_q[k] <= '0;
        for (int unsigned d = 0; d < DELAY; d++) begin
          hist_i[k][d] <= '0;
          hist_q[k][d] <= '0;
        end
      end
    end else if (o_ready) begin
      comb_vld <= cin_vld;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (cin_vld[k]) begin
          comb_i[k]    <= cin_i[k] - hist_i[k][DELAY-1];
          comb_q[k]    <= cin_q[k] - hist_q[k][DELAY-1];
          hist_i[k][0] <= cin_i[k];
          hist_q[k][0] <= cin_q[k];
          for (int unsigned d = 1; d < DELAY; d++) begin
            hist_i[k][d] <= hist_i[k][d-1];
            hist_q[k][d] <= hist_q[k][d-1];
          end
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      hold_full <= 1'b0;
      hold_i    <= '0;
      hold_q    <= '0;
      phase     <= '0;
    end else begin
      if (o_ready && comb_vld[STAGES-1]) begin
        hold_i    <= comb_i[STAGES-1];
        hold_q    <= comb_q[STAGES-1];
        hold_full <= 1'b1;
      end else if (take) begin
        hold_full <= 1'b0;
      end
      if (i_strobe) begin
        phase <= (phase == PHASE_W'(FACTOR - 1)) ? '0 : phase + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      integ_vld <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        integ_i[k] <= '0;
        integ_q[k] <= '0;
      end
    end else begin
      integ_vld <= iin_vld;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (iin_vld[k]) begin
          integ_i[k] <= integ_i[k] + iin_i[k];
          integ_q[k] <= integ_q[k] + iin_q[k];
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid     <= 1'b0;
      o_underrun  <= 1'b0;
      o_inph_data <= '0;
      o_quad_data <= '0;
    end else begin
      o_valid    <= integ_vld[STAGES-1];
      o_underrun <= slot0 && !hold_full;
      if (integ_vld[STAGES-1]) begin
        o_inph_data <= integ_i[STAGES-1][OUT_SHIFT +: WIDTH];
        o_quad_data <= integ_q[STAGES-1][OUT_SHIFT +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_cic_interp.sv
// Scoreboard bench for cic_interp: instance A is a 1-stage ZOH config (R=4),
// instance B the default filter with OUT_SHIFT=0 driven with an impulse.
module tb_cic_interp;
  localparam int AF = 4;
  localparam int AS = 1;
  localparam int BF = 313;
  localparam int BD = 2;
  localparam int BS = 5;
  localparam int BL = BS * (BF * BD - 1) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic a_rst, a_valid, a_ready, a_strobe, a_ovalid, a_under;
  logic [15:0] a_di, a_dq, a_oi, a_oq;
  logic b_rst, b_valid, b_ready, b_strobe, b_ovalid, b_under;
  logic [15:0] b_di, b_dq, b_oi, b_oq;

  cic_interp #(.WIDTH(16), .FACTOR(AF), .DELAY(1), .STAGES(AS), .ACC_WIDTH(20), .OUT_SHIFT(0)) dut_a (
    .i_clock(clk), .i_reset(a_rst), .i_inph_data(a_di), .i_quad_data(a_dq),
    .i_valid(a_valid), .o_ready(a_ready), .i_strobe(a_strobe),
    .o_inph_data(a_oi), .o_quad_data(a_oq), .o_valid(a_ovalid), .o_underrun(a_under));

  cic_interp #(.WIDTH(16), .FACTOR(BF), .DELAY(BD), .STAGES(BS), .ACC_WIDTH(56), .OUT_SHIFT(0)) dut_b (
    .i_clock(clk), .i_reset(b_rst), .i_inph_data(b_di), .i_quad_data(b_dq),
    .i_valid(b_valid), .o_ready(b_ready), .i_strobe(b_strobe),
    .o_inph_data(b_oi), .o_quad_data(b_oq), .o_valid(b_ovalid), .o_underrun(b_under));

  typedef struct { logic [15:0] i; logic [15:0] q; int at; } exp_t;
  typedef struct { logic u; int at; } und_t;
  exp_t aq[$], bq[$];
  und_t au[$], bu[$];
  exp_t ea, eb;
  logic a_acc, b_acc, a_prev_valid = 1'b0, a_gap_chk = 1'b0;
  longint h [BL];
  longint hx [BL];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] s16(input int v);
    return v[15:0];
  endfunction

  function automatic logic [15:0] h16(input int n);
    longint v;
    v = (n < BL) ? h[n] : 64'sd0;
    return v[15:0];
  endfunction

  // One cycle, negedge to negedge; a strobe pushes its expected output and underrun.
  task automatic a_step(input logic strobe, input logic [15:0] ei, input logic [15:0] eq, input logic eu);
    a_strobe = strobe;
    if (strobe) begin
      aq.push_back('{ei, eq, cyc + 1 + AS});
      au.push_back('{eu, cyc + 1});
    end
    #1 a_acc = a_valid && a_ready;
    @(negedge clk);
    a_strobe = 1'b0;
  endtask

  task automatic b_step(input logic strobe, input logic [15:0] ei);
    b_strobe = strobe;
    if (strobe) begin
      bq.push_back('{ei, 16'd0, cyc + 1 + BS});
      bu.push_back('{1'b0, cyc + 1});
    end
    #1 b_acc = b_valid && b_ready;
    @(negedge clk);
    b_strobe = 1'b0;
  endtask

  task automatic a_reset();
    a_rst = 1'b1; a_valid = 1'b0; a_strobe = 1'b0;
    aq.delete(); au.delete();
    @(negedge clk);
    a_rst = 1'b0;
  endtask

  task automatic a_zoh();
    a_valid = 1'b1; a_di = 16'd100; a_dq = s16(-50);
    a_step(1'b0, '0, '0, 1'b0);
    chk("zoh_accept_0", 32'(a_acc), 32'd1);
    a_di = 16'd7; a_dq = 16'd7;
    a_step(1'b0, '0, '0, 1'b0);
    chk("zoh_accept_1", 32'(a_acc), 32'd1);
    a_valid = 1'b0;
    for (int j = 0; j < 8; j++)
      a_step(1'b1, (j < 4) ? 16'd100 : 16'd7, (j < 4) ? s16(-50) : 16'd7, 1'b0);
    repeat (4) a_step(1'b0, '0, '0, 1'b0);
  endtask

  initial begin : mon_a
    forever begin
      @(posedge clk);
      #1;
      if (au.size() > 0 && au[0].at == cyc) begin
        chk("a_underrun", 32'(a_under), 32'(au[0].u));
        void'(au.pop_front());
      end else begin
        chk("a_underrun_idle", 32'(a_under), 32'd0);
      end
      if (a_ovalid) begin
        if (a_gap_chk) chk("a_valid_back_to_back", 32'(a_prev_valid), 32'd0);
        if (aq.size() == 0) begin
          chk("a_spurious_valid", 32'(a_ovalid), 32'd0);
        end else begin
          ea = aq.pop_front();
          chk("a_inph", 32'(a_oi), 32'(ea.i));
          chk("a_quad", 32'(a_oq), 32'(ea.q));
          chk("a_latency", 32'(cyc), 32'(ea.at));
        end
      end else if (aq.size() > 0 && aq[0].at <= cyc) begin
        chk("a_missing_valid", 32'(a_ovalid), 32'd1);
        void'(aq.pop_front());
      end
      a_prev_valid = a_ovalid;
    end
  end

  initial begin : mon_b
    forever begin
      @(posedge clk);
      #1;
      if (bu.size() > 0 && bu[0].at == cyc) begin
        chk("b_underrun", 32'(b_under), 32'(bu[0].u));
        void'(bu.pop_front());
      end else begin
        chk("b_underrun_idle", 32'(b_under), 32'd0);
      end
      if (b_ovalid) begin
        if (bq.size() == 0) begin
          chk("b_spurious_valid", 32'(b_ovalid), 32'd0);
        end else begin
          eb = bq.pop_front();
          chk("b_inph", 32'(b_oi), 32'(eb.i));
          chk("b_quad", 32'(b_oq), 32'(eb.q));
          chk("b_latency", 32'(cyc), 32'(eb.at));
        end
      end else if (bq.size() > 0 && bq[0].at <= cyc) begin
        chk("b_missing_valid", 32'(b_ovalid), 32'd1);
        void'(bq.pop_front());
      end
    end
  end

  initial begin : main
    int idx;
    int cnt;
    logic [15:0] si [16];
    logic [15:0] sq [16];

    a_rst = 1'b1; a_valid = 1'b0; a_strobe = 1'b0; a_di = '0; a_dq = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_strobe = 1'b0; b_di = '0; b_dq = '0;

    // Impulse response of the high-rate filter: BS boxcars of length R*M.
    for (int n = 0; n < BL; n++) h[n] = (n == 0) ? 64'sd1 : 64'sd0;
    for (int s = 0; s < BS; s++) begin
      longint run;
      run = 0;
      for (int n = 0; n < BL; n++) begin
        run += h[n];
        if (n >= BF * BD) run -= h[n - BF * BD];
        hx[n] = run;
      end
      for (int n = 0; n < BL; n++) h[n] = hx[n];
    end

    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(a_ready), 32'd1);
    chk("reset_valid", 32'(a_ovalid), 32'd0);
    chk("reset_underrun", 32'(a_under), 32'd0);
    chk("reset_inph", 32'(a_oi), 32'd0);
    chk("reset_quad", 32'(b_oq), 32'd0);
    a_rst = 1'b0; b_rst = 1'b0;

    // ZOH sequence.
    a_zoh();

    // Backpressure on A: distinct samples, order and multiplicity via ZOH outputs.
    a_reset();
    for (int k = 0; k < 16; k++) begin
      si[k] = s16(11 * (k + 1));
      sq[k] = s16(1000 - 3 * k);
    end
    idx = 0;
    a_valid = 1'b1;
    repeat (8) begin
      a_di = si[idx]; a_dq = sq[idx];
      a_step(1'b0, '0, '0, 1'b0);
      if (a_acc) idx++;
    end
    chk("a_bp_idle_accepts", 32'(idx), 32'(AS + 1));
    for (int j = 0; j < 12; j++) begin
      a_di = si[idx]; a_dq = sq[idx];
      a_step(1'b1, si[j / AF], sq[j / AF], 1'b0);
      if (a_acc) idx++;
      if (j == AF - 1) chk("a_bp_frame_accepts", 32'(idx), 32'(AS + 2));
    end
    a_valid = 1'b0;
    repeat (4) a_step(1'b0, '0, '0, 1'b0);

    // Underrun: no data, pulse on strobes 1, 5, 9.
    a_reset();
    for (int j = 0; j < 12; j++) a_step(1'b1, '0, '0, (j % AF) == 0);
    repeat (4) a_step(1'b0, '0, '0, 1'b0);

    // Strobe every third cycle with steady input.
    a_reset();
    a_valid = 1'b1; a_di = 16'd1000; a_dq = s16(-1000);
    repeat (3) a_step(1'b0, '0, '0, 1'b0);
    a_gap_chk = 1'b1;
    repeat (12) begin
      a_step(1'b1, 16'd1000, s16(-1000), 1'b0);
      repeat (2) a_step(1'b0, '0, '0, 1'b0);
    end
    repeat (4) a_step(1'b0, '0, '0, 1'b0);
    a_gap_chk = 1'b0;
    a_valid = 1'b0;

    // Reset mid-burst, then a fresh ZOH run must reproduce the first one.
    a_reset();
    a_valid = 1'b1; a_di = 16'd500; a_dq = 16'd3;
    repeat (3) a_step(1'b0, '0, '0, 1'b0);
    repeat (6) a_step(1'b1, 16'd500, 16'd3, 1'b0);
    a_reset();
    chk("midrst_valid", 32'(a_ovalid), 32'd0);
    chk("midrst_ready", 32'(a_ready), 32'd1);
    chk("midrst_underrun", 32'(a_under), 32'd0);
    chk("midrst_inph", 32'(a_oi), 32'd0);
    a_zoh();

    // Instance B: impulse with backpressure accounting.
    cnt = 0;
    b_valid = 1'b1; b_di = 16'd1; b_dq = 16'd0;
    repeat (20) begin
      b_step(1'b0, '0);
      if (b_acc) begin
        cnt++;
        b_di = 16'd0;
      end
    end
    chk("b_bp_idle_accepts", 32'(cnt), 32'(BS + 1));
    for (int n = 0; n < BL + 4; n++) begin
      b_step(1'b1, h16(n));
      if (b_acc) cnt++;
      if (n == BF - 1) chk("b_bp_frame_accepts", 32'(cnt), 32'(BS + 2));
    end
    b_valid = 1'b0;
    repeat (BS + 4) b_step(1'b0, '0);

    chk("a_queue_drained", 32'(aq.size()), 32'd0);
    chk("b_queue_drained", 32'(bq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cic_interp.md
Name: cic_interp

Overview:
- I/Q cascaded-integrator-comb interpolator; the transmit-side counterpart of the team's CIC decimator.
- Accepts low-rate I/Q samples through a valid/ready handshake and runs STAGES comb sections at the low rate.
- Zero-stuffs by FACTOR, paced by a high-rate output strobe, and runs STAGES integrator sections at the high rate.
- Sits between the baseband sample source and the DAC-rate datapath.

Parameters:
- WIDTH, 16: I/Q input and output sample width, two's complement.
- FACTOR, 313: interpolation ratio R, at least 2.
- DELAY, 2: comb differential delay M, at least 1.
- STAGES, 5: number of comb sections, equal to the number of integrator sections, at least 1.
- ACC_WIDTH, 56: internal comb/integrator width; all arithmetic wraps modulo 2^ACC_WIDTH.
- OUT_SHIFT, 39: output LSB position; OUT_SHIFT+WIDTH must not exceed ACC_WIDTH.

Ports:
- i_clock  in  1  single clock.
- i_reset  in  1  synchronous, active-high reset.
- i_inph_data  in  WIDTH  input in-phase sample.
- i_quad_data  in  WIDTH  input quadrature sample.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block can accept an input sample this cycle.
- i_strobe  in  1  high-rate output tick; one output sample is produced per strobe.
- o_inph_data  out  WIDTH  output in-phase sample.
- o_quad_data  out  WIDTH  output quadrature sample.
- o_valid  out  1  output sample valid, one cycle per strobe.
- o_underrun  out  1  one-cycle pulse: a zero-stuff slot needed a sample and none was held.

Behaviour:
- Reset: all comb delay lines, integrators, hold register and phase counter clear to 0. Outputs after reset: o_valid=0, o_underrun=0, o_inph_data=0, o_quad_data=0, o_ready=1 in the first cycle after reset.
- Input handshake: a transfer occurs when i_valid and o_ready are both high. o_ready = NOT(hold_full) OR take, where take is the upsampler consuming the hold register in the same cycle.
- Input sign-extension: input is sign-extended to ACC_WIDTH before the first comb.
- Comb pipeline: each comb stage is registered and updates only when its input valid is high: y = x - x[n-DELAY], where the history is a DELAY-deep shift register advanced on valid. Total comb latency is STAGES cycles. The comb output writes the hold register and sets hold_full.
- Backpressure: with hold_full high and no take, o_ready is low, so at most STAGES samples can be in flight in the comb pipeline. The comb pipeline advances only when it cannot overwrite a full hold register: the comb valid chain is gated by o_ready.
- Phase counter: counts 0..FACTOR-1 and advances only on i_strobe, wrapping FACTOR-1 -> 0.
- Strobe with counter = 0 and hold_full: take, inject the hold value, clear hold_full. If an input is accepted in the same cycle, no sample is lost; the pipeline output arriving that cycle refills the hold register.
- Strobe with counter = 0 and hold empty: inject 0, pulse o_underrun for one cycle, counter still advances.
- Strobe with counter ≠ 0: inject 0.
- Integrator pipeline: each integrator stage is registered and accumulates acc += x when its input valid is high. The valid is the strobe delayed one cycle per stage.
- Output: o_*_data = acc_last[OUT_SHIFT+WIDTH-1 : OUT_SHIFT], registered. o_valid asserts exactly STAGES+1 cycles after the strobe that created the slot. Outputs hold their value while o_valid=0.
- Cycle budget: strobes are one per cycle at most; back-to-back strobes are legal.
- Overflow: integrators wrap; the result is correct when ACC_WIDTH is at least WIDTH + ceil(STAGES*log2(FACTOR*DELAY)) - log2(FACTOR). No saturation.
- Reset mid-operation: everything is discarded with no output pulse. The first output after reset comes from a strobe issued after reset deasserts.
- Simultaneous conditions: the pulse o_underrun and o_valid for the same slot are independent. o_underrun is emitted in the strobe cycle + 1.

Test Plan:
- ZOH check, FACTOR=4, DELAY=1, STAGES=1, ACC_WIDTH=20, OUT_SHIFT=0. Feed I=100, Q=-50, then I=7, Q=7, strobe every cycle. Required: outputs 100,100,100,100 and -50 x4, then 7 x4, with the first o_valid 2 cycles after the first strobe.
- Impulse with defaults but OUT_SHIFT=0, ACC_WIDTH=56. Feed a single I=1 then zeros. Required: the I output sequence equals the CIC impulse response, summing to FACTOR^(STAGES-1)*DELAY^STAGES; Q=0 throughout.
- Backpressure: hold i_valid=1 with no strobes. Required: o_ready drops after STAGES+1 accepted samples. After one FACTOR cycle of strobes, exactly one more sample is accepted and none is lost or duplicated.
- Underrun, FACTOR=4. Strobes with i_valid=0. Required: o_underrun pulses on strobes 1, 5, 9 and outputs are all 0.
- Strobe gaps: strobe every 3rd cycle, steady input 1000, ZOH config. Required: every o_valid output equals 1000 and o_valid never occurs on consecutive cycles.
- Reset mid-burst: assert i_reset for 1 cycle during streaming. Required: o_valid=0 and o_ready=1 in the next cycle, counter restarts, and post-reset outputs match a fresh run.
